uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter, 8N1 framing (1 start bit, 8 data bits LSB first, 1 stop bit), for the same serial link served by the existing UART receive path. Bytes enter through a valid/ready handshake into a small internal FIFO, so a producer can queue several bytes without tracking line timing. Frames are then serialised onto TXD. Bit period is set by a clock-cycle count parameter; the default matches 9600 bps at 100 MHz.

Parameters:
BAUD_SET_COUNTER, 10416, clk cycles per bit (100 MHz / 9600 bps); legal range 4..16383 (14-bit counter)
FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
i_tx_data  input  8  byte to transmit
i_tx_valid  input  1  i_tx_data valid this cycle
o_tx_ready  output  1  FIFO can accept; transfer on rising edge when i_tx_valid && o_tx_ready
TXD  output  1  serial line, idle high, registered
tx_busy  output  1  high while a frame is on the line (START/DATA/STOP states)
tx_done  output  1  one-cycle pulse at end of each stop bit

Behaviour:
- Reset (rst_n sampled low at a clk edge): TXD=1, tx_busy=0, tx_done=0, FIFO emptied, bit counter=0, bit index=0, state=IDLE. Any frame in progress is abandoned; TXD is high on the cycle after the reset edge.
- While rst_n is low: no writes accepted; o_tx_ready=0.
- o_tx_ready = !fifo_full && rst_n (combinational from registered FIFO count).
- FIFO rules:
  - Push when valid && ready.
  - Pop only by the FSM, when loading a frame.
  - Simultaneous push and pop: allowed, count unchanged.
  - Push while full: impossible, because ready=0.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TXD=1. If FIFO not empty, pop the head into an 8-bit shift register, clear the counter, go to START.
  - START: TXD=0 for BAUD_SET_COUNTER cycles. Counter runs 0..BAUD_SET_COUNTER-1. At terminal count, clear the counter and go to DATA with bit index 0.
  - DATA: TXD=shift_reg[0]. At each terminal count, shift right and increment the bit index. After bit index 7 completes, go to STOP.
  - STOP: TXD=1 for BAUD_SET_COUNTER cycles. At terminal count, pulse tx_done for exactly 1 cycle.
    - If the FIFO is not empty: pop and go directly to START (no idle gap between frames).
    - Otherwise: go to IDLE.
- Frame length: exactly 10*BAUD_SET_COUNTER cycles.
- Latency: with the FIFO empty and the FSM in IDLE, a byte accepted at edge N appears as TXD=0 after edge N+2 (FIFO registers at N, FSM pops at N+1, TXD registered low at N+2).
- TXD is driven from a register, so there are no glitches.
- i_tx_data is not sampled when there is no handshake, and changes on it have no effect.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W = 8
  - default BAUD_SET_COUNTER value (shared with the receiver)
  - state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3
- One natural sub-module, uart_tx_fifo: synchronous FIFO with a parameterised FIFO_DEPTH. Ports: push, pop, din, dout, full, empty. Same clk and synchronous active-low rst_n.
- Serialiser FSM stays in uart_tx.

Test Plan:
- BAUD_SET_COUNTER=16 for all sims. Single byte 0x55 into idle block:
  - TXD low 2 cycles after accept.
  - Line sequence 0,1,0,1,0,1,0,1,0,1, each held 16 cycles.
  - tx_done pulses once, 160 cycles after the TXD falling edge.
  - tx_busy high for exactly 160 cycles.
- Byte 0xA3 -> data bits on line 1,1,0,0,0,1,0,1 (LSB first). A reference receiver model decodes 0xA3 and sees the stop bit high.
- Burst: i_tx_valid held high with bytes 0x01..0x06:
  - First byte pops immediately; 5 bytes are accepted, then o_tx_ready drops with the FIFO full (4).
  - 0x06 is accepted once the first frame's STOP pops.
  - All 6 frames are back-to-back with no idle cycles, and 6 tx_done pulses arrive 160 cycles apart.
- Simultaneous push/pop: push a byte in the same cycle STOP pops the head. FIFO count unchanged, and byte order is preserved.
- Reset mid-frame: rst_n low for 1 cycle during DATA bit 3:
  - Next cycle: TXD=1, tx_busy=0, FIFO empty, o_tx_ready=1 once rst_n is high.
  - No tx_done is generated for the abandoned frame.
  - A following 0x3C transmits correctly.
- Handshake hold-off: i_tx_valid high while o_tx_ready=0 for 50 cycles, with changing data. Nothing is accepted and no extra frames are sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_pkg;
    localparam int UART_DATA_W          = 8;
    localparam int BAUD_SET_COUNTER_DEF = 10416;  // 100 MHz / 9600 bps
    localparam int BAUD_CNT_W           = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;
endpackage

// File: rtl/uart_tx_if.sv
// Byte-in handshake plus serial-line status of the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] i_tx_data;
    logic                   i_tx_valid;
    logic                   o_tx_ready;
    logic                   TXD;
    logic                   tx_busy;
    logic                   tx_done;

    modport master (
        output i_tx_data, i_tx_valid,
        input  o_tx_ready, TXD, tx_busy, tx_done
    );

    modport slave (
        input  i_tx_data, i_tx_valid,
        output o_tx_ready, TXD, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; head entry is visible on dout whenever not empty.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered byte input, registered serial output.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_SET_COUNTER = BAUD_SET_COUNTER_DEF,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_tx_if.slave    tx_if
);
    localparam logic [BAUD_CNT_W-1:0] TC = BAUD_CNT_W'(BAUD_SET_COUNTER - 1);

    uart_state_e            state_q, state_d;
    logic [BAUD_CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic                   txd_q, txd_d;
    logic                   busy_q, busy_d;
    logic                   done_pend_q, done_pend_d;
    logic                   done_q;

    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [UART_DATA_W-1:0] fifo_dout;
    logic                   tc;

    assign tx_if.o_tx_ready = !fifo_full && rst_n;
    assign fifo_push        = tx_if.i_tx_valid && tx_if.o_tx_ready;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (UART_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (tx_if.i_tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tc = (cnt_q == TC);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        fifo_pop    = 1'b0;
        done_pend_d = 1'b0;
        if (state_q != IDLE) cnt_d = cnt_q + BAUD_CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_dout;
                    cnt_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (tc) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tc) begin
                    cnt_d     = '0;
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (tc) begin
                    cnt_d       = '0;
                    done_pend_d = 1'b1;
                    // Chain straight into the next frame so queued bytes leave no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_dout;
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line outputs trail the state by one cycle; tx_done trails once more so it
    // marks the cycle right after the stop bit has left the TXD register.
    always_comb begin
        busy_d = (state_q != IDLE);
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            done_pend_q <= done_pend_d;
            done_q      <= done_pend_q;
        end
    end

    assign tx_if.TXD     = txd_q;
    assign tx_if.tx_busy = busy_q;
    assign tx_if.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per bit with a mid-bit sampling receiver model.
module tb_uart_tx;
    localparam int BAUD = 16;
    localparam int PER  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_if tx_if();

    uart_tx #(
        .BAUD_SET_COUNTER (BAUD),
        .FIFO_DEPTH       (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tx_if (tx_if)
    );

    always #(PER/2) clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference receiver: samples each bit at its middle, drops frames cut by reset.
    logic       mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [9:0] mon_sh  = '0;
    time        mon_st  = 0;
    logic [7:0] rx_q[$];
    logic       rx_stop_q[$];
    logic       rx_start_q[$];
    time        rx_st_q[$];
    time        done_q[$];
    int         acc_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act <= 1'b0;
        end else if (!mon_act) begin
            if (tx_if.TXD === 1'b0) begin
                mon_act <= 1'b1;
                mon_cnt <= 1;
                mon_st  <= $time;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt % BAUD == BAUD/2) mon_sh[mon_cnt/BAUD] <= tx_if.TXD;
            if (mon_cnt == 10*BAUD-1) begin
                mon_act <= 1'b0;
                rx_q.push_back(mon_sh[8:1]);
                rx_stop_q.push_back(mon_sh[9]);
                rx_start_q.push_back(mon_sh[0]);
                rx_st_q.push_back(mon_st);
            end
        end
    end

    always @(negedge clk) begin
        if (tx_if.tx_done === 1'b1) done_q.push_back($time);
        if (rst_n && tx_if.i_tx_valid && tx_if.o_tx_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        tx_if.i_tx_data  = b;
        tx_if.i_tx_valid = 1'b1;
        while (tx_if.o_tx_ready !== 1'b1 && w < 2000) begin
            tick(1);
            w++;
        end
        tick(1);
        tx_if.i_tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n, input int lim);
        int w;
        w = 0;
        while (rx_q.size() < n && w < lim) begin
            tick(1);
            w++;
        end
        chk(tag, 32'(rx_q.size() >= n), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       hs;
        int         brx, bdn, bacc, idx, cyc, j;
        int         acc_edge[6];

        tx_if.i_tx_data  = 8'h00;
        tx_if.i_tx_valid = 1'b0;

        // Reset state
        tick(3);
        chk("rst_txd",   32'(tx_if.TXD),        32'd1);
        chk("rst_busy",  32'(tx_if.tx_busy),    32'd0);
        chk("rst_done",  32'(tx_if.tx_done),    32'd0);
        chk("rst_ready", 32'(tx_if.o_tx_ready), 32'd0);
        rst_n = 1'b1;
        tick(1);
        chk("ready_after_rst", 32'(tx_if.o_tx_ready), 32'd1);

        // 0x55: exact cycle-by-cycle line shape, latency, busy window, done timing
        bdn = done_q.size();
        brx = rx_q.size();
        b = 8'h55;
        send(b);
        chk("lat_txd_n0", 32'(tx_if.TXD), 32'd1);
        tick(1);
        chk("lat_txd_n1",  32'(tx_if.TXD),     32'd1);
        chk("lat_busy_n1", 32'(tx_if.tx_busy), 32'd0);
        tick(1);
        for (int c = 0; c < 10*BAUD; c++) begin
            j = c / BAUD;
            chk($sformatf("x55_txd_c%0d", c), 32'(tx_if.TXD),
                32'((j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1]));
            chk($sformatf("x55_busy_c%0d", c), 32'(tx_if.tx_busy), 32'd1);
            if (c > 0) chk($sformatf("x55_nodone_c%0d", c), 32'(tx_if.tx_done), 32'd0);
            tick(1);
        end
        chk("x55_done_at_160", 32'(tx_if.tx_done), 32'd1);
        chk("x55_busy_end",    32'(tx_if.tx_busy), 32'd0);
        chk("x55_txd_idle",    32'(tx_if.TXD),     32'd1);
        tick(1);
        chk("x55_done_pulse",  32'(tx_if.tx_done), 32'd0);
        chk("x55_done_count",  32'(done_q.size() - bdn), 32'd1);
        chk("x55_rx_byte",     32'(rx_q[brx]), 32'h55);

        // 0xA3 through the receiver model
        tick(5);
        brx = rx_q.size();
        send(8'hA3);
        wait_rx("a3_wait", brx + 1, 400);
        chk("a3_rx_byte",  32'(rx_q[brx]),       32'hA3);
        chk("a3_rx_start", 32'(rx_start_q[brx]), 32'd0);
        chk("a3_rx_stop",  32'(rx_stop_q[brx]),  32'd1);

        // Burst 0x01..0x06 with valid held high
        tick(10);
        brx = rx_q.size();
        bdn = done_q.size();
        idx = 0;
        cyc = 0;
        tx_if.i_tx_data  = 8'h01;
        tx_if.i_tx_valid = 1'b1;
        while (idx < 6 && cyc < 1000) begin
            hs = tx_if.o_tx_ready;
            tick(1);
            cyc++;
            if (hs) begin
                acc_edge[idx] = cyc;
                idx++;
                tx_if.i_tx_data = 8'(idx + 1);
            end
            if (cyc == 6) chk("burst_full_ready", 32'(tx_if.o_tx_ready), 32'd0);
        end
        tx_if.i_tx_valid = 1'b0;
        chk("burst_accepts",  32'(idx),         32'd6);
        chk("burst_5th_edge", 32'(acc_edge[4]), 32'd5);
        chk("burst_6th_edge", 32'(acc_edge[5]), 32'd163);
        wait_rx("burst_wait", brx + 6, 1200);
        tick(5);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("burst_byte%0d", i), 32'(rx_q[brx+i]),      32'(i + 1));
            chk($sformatf("burst_stop%0d", i), 32'(rx_stop_q[brx+i]), 32'd1);
        end
        for (int i = 1; i < 6; i++) begin
            chk($sformatf("burst_gap%0d", i),  32'(rx_st_q[brx+i] - rx_st_q[brx+i-1]), 32'(10*BAUD*PER));
            chk($sformatf("burst_done_gap%0d", i), 32'(done_q[bdn+i] - done_q[bdn+i-1]), 32'(10*BAUD*PER));
        end
        chk("burst_done_count", 32'(done_q.size() - bdn), 32'd6);

        // Push in the same cycle STOP pops the head
        tick(10);
        brx = rx_q.size();
        send(8'h11);
        tick(9);
        send(8'h22);
        tick(150);
        chk("pp_count_before", 32'(dut.u_fifo.count_q), 32'd1);
        tx_if.i_tx_data  = 8'h33;
        tx_if.i_tx_valid = 1'b1;
        tick(1);
        tx_if.i_tx_valid = 1'b0;
        chk("pp_count_after", 32'(dut.u_fifo.count_q), 32'd1);
        wait_rx("pp_wait", brx + 3, 800);
        chk("pp_byte0", 32'(rx_q[brx]),   32'h11);
        chk("pp_byte1", 32'(rx_q[brx+1]), 32'h22);
        chk("pp_byte2", 32'(rx_q[brx+2]), 32'h33);
        chk("pp_gap1",  32'(rx_st_q[brx+1] - rx_st_q[brx]),   32'(10*BAUD*PER));
        chk("pp_gap2",  32'(rx_st_q[brx+2] - rx_st_q[brx+1]), 32'(10*BAUD*PER));

        // Reset during DATA bit 3 with a second byte still queued
        tick(10);
        brx = rx_q.size();
        bdn = done_q.size();
        send(8'h5A);
        tick(4);
        send(8'h77);
        tick(64);
        chk("mid_bit_idx", 32'(dut.bit_idx_q), 32'd3);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_txd",   32'(tx_if.TXD),          32'd1);
        chk("mid_rst_busy",  32'(tx_if.tx_busy),      32'd0);
        chk("mid_rst_done",  32'(tx_if.tx_done),      32'd0);
        chk("mid_rst_ready", 32'(tx_if.o_tx_ready),   32'd0);
        chk("mid_rst_empty", 32'(dut.u_fifo.empty),   32'd1);
        rst_n = 1'b1;
        #1;
        chk("mid_ready_release", 32'(tx_if.o_tx_ready), 32'd1);
        tick(200);
        chk("mid_no_done",  32'(done_q.size() - bdn), 32'd0);
        chk("mid_no_frame", 32'(rx_q.size() - brx),   32'd0);
        chk("mid_idle_txd", 32'(tx_if.TXD),           32'd1);
        send(8'h3C);
        wait_rx("mid_3c_wait", brx + 1, 400);
        tick(5);
        chk("mid_3c_byte",   32'(rx_q[brx]),            32'h3C);
        chk("mid_3c_stop",   32'(rx_stop_q[brx]),       32'd1);
        chk("mid_3c_frames", 32'(rx_q.size() - brx),    32'd1);
        chk("mid_3c_done",   32'(done_q.size() - bdn),  32'd1);

        // Hold-off: valid stays high with changing data while the FIFO is full
        tick(10);
        brx  = rx_q.size();
        bacc = acc_cnt;
        tx_if.i_tx_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tx_if.i_tx_data = 8'(8'hC0 + i);
            tick(1);
            if (i == 30) chk("hold_ready_low", 32'(tx_if.o_tx_ready), 32'd0);
        end
        tx_if.i_tx_valid = 1'b0;
        chk("hold_accepts", 32'(acc_cnt - bacc), 32'd5);
        wait_rx("hold_wait", brx + 5, 1000);
        tick(200);
        chk("hold_frames", 32'(rx_q.size() - brx), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("hold_byte%0d", i), 32'(rx_q[brx+i]), 32'(8'hC0 + i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
